gray_ptr_sync_tracker: RTL and testbench
========================================

// Module: gray_ptr_sync_tracker
// PURPOSE
//   Read-side pointer engine for the PCS RX elastic buffer. Synchronises the
//   write pointer, which arrives as Gray code from the recovered-clock domain,
//   through a parametrised flop chain and decodes it to binary. It also owns the
//   local read pointer (binary and Gray), computes buffer occupancy, and raises
//   empty/full/watermark flags for SKP add/delete control.
// PARAMETERS
//   PTR_WIDTH    5   pointer width = log2(depth)+1 wrap bit; depth = 2**(PTR_WIDTH-1)
//   SYNC_STAGES  2   synchroniser flops on remote_ptr_gray, >=2
//   LOW_MARK     6   level_low asserted when occupancy < LOW_MARK
//   HIGH_MARK    10  level_high asserted when occupancy > HIGH_MARK
// PORTS
//   clk              in   1          read-domain clock
//   rst_n            in   1          synchronous active-low reset
//   remote_ptr_gray  in   PTR_WIDTH  write pointer, Gray, asynchronous to clk
//   local_inc        in   1          request to advance read pointer by one
//   local_ptr_bin    out  PTR_WIDTH  read pointer, binary (registered)
//   local_ptr_gray   out  PTR_WIDTH  read pointer, Gray (registered, same cycle as bin)
//   remote_ptr_bin   out  PTR_WIDTH  synchronised + decoded write pointer (registered)
//   occupancy        out  PTR_WIDTH  remote_ptr_bin - local_ptr_bin, modulo 2**PTR_WIDTH
//   empty            out  1          occupancy == 0
//   full             out  1          occupancy == 2**(PTR_WIDTH-1)
//   level_low        out  1          occupancy < LOW_MARK
//   level_high       out  1          occupancy > HIGH_MARK
//   gray_err         out  1          sticky sync-integrity error (see CONFIGURATION)
// BEHAVIOUR
// - Clock clk; reset is synchronous and active-low (rst_n), sampled on the rising clk edge.
// - Reset: sync chain, remote_ptr_bin, local_ptr_bin, local_ptr_gray and gray_err
//   all go to 0. Derived outputs are therefore occupancy=0, empty=1, full=0,
//   level_low=1 (LOW_MARK>0) and level_high=0.
// - Sync: sync[0]<=remote_ptr_gray; sync[k]<=sync[k-1]; only Gray values cross.
// - Decode: remote_ptr_bin <= gray2bin(sync[SYNC_STAGES-1]); bin[i] = XOR of gray[W-1:i].
//   Latency from a remote_ptr_gray change to remote_ptr_bin is SYNC_STAGES+1 cycles.
// - Local pointer: advances when local_inc && !empty, with empty evaluated from the
//   current registered state. local_inc while empty is ignored; the pointer never
//   underruns. Wraps from 2**PTR_WIDTH-1 to 0.
// - local_ptr_gray <= bin2gray(next local_ptr_bin) = nxt ^ (nxt>>1); it changes in the
//   same cycle as local_ptr_bin.
// - occupancy and all flags are combinational from flops only; no input-to-output path.
// - Simultaneous remote update and local_inc: both registers update that cycle.
//   occupancy reflects both changes on the next cycle.
// - Reset mid-operation: all state returns to 0 on the next edge. Sync-chain contents
//   are discarded. Remote values reappear SYNC_STAGES+1 cycles after rst_n=1.
// - Occupancy > depth is illegal and indicates a write overrun; the wrapped value is
//   reported unchanged.
// CONFIGURATION
//   GRAY_PTR_CHECK_EN defined: a register holds the previous sync[SYNC_STAGES-1]. gray_err
//     sets, sticky until reset, in either case:
//     - consecutive synchronised Gray values differ in more than 1 bit;
//     - occupancy > 2**(PTR_WIDTH-1).
//     gray_err asserts 1 cycle after the offending value reaches sync[SYNC_STAGES-1].
//   GRAY_PTR_CHECK_EN undefined: no check logic is built; gray_err is tied to 0.
// TESTING (PTR_WIDTH=5, SYNC_STAGES=2, LOW_MARK=6, HIGH_MARK=10)
// 1 rst_n=0 for 3 cycles, remote_ptr_gray=5'b10110 -> all pointers 0, empty=1,
//   level_low=1, gray_err=0.
// 2 remote Gray 00000,00001,00011,00010,00110,00111, one step per cycle ->
//   remote_ptr_bin 0..5, each 3 cycles after its input; final occupancy=5, level_low=1.
// 3 local_inc=1 held for 7 cycles from case 2 state -> local_ptr_bin 1..5, then holds
//   at 5; local_ptr_gray=00111; empty=1.
// 4 Wrap: local=28; remote steps to bin 2 (Gray 00011) via 29,30,31,0,1 -> occupancy=6.
//   Five increments take local 31->0 with Gray 10000->00000.
// 5 remote bin 16 (Gray 11000), local 0 -> occupancy=16, full=1, level_high=1.
//   Simultaneous remote step and local_inc -> occupancy unchanged.
// 6 GRAY_PTR_CHECK_EN: remote Gray jumps 00000->00011 -> gray_err=1 3 cycles later,
//   stays 1 until rst_n=0. Macro undefined -> gray_err stays 0.

Source files
------------

// File: rtl/gray_ptr_sync_tracker.sv
// Purpose     : read-side pointer engine for the PCS RX elastic buffer.
// Latency     : remote_ptr_gray change -> remote_ptr_bin in SYNC_STAGES+1 cycles; local_inc -> local_ptr_* in 1 cycle.
// Backpressure: none; a local_inc while the buffer is empty is dropped, so the read pointer never underruns.
//
// The write pointer arrives as Gray code from the recovered-clock domain. It
// crosses through a SYNC_STAGES flop chain, is decoded to binary and
// registered as remote_ptr_bin. The block also owns the local read pointer
// (binary and Gray) and derives occupancy plus empty/full/watermark flags
// that feed SKP add/delete control.
//
// Ports
//   clk              in   read-domain clock
//   rst_n            in   synchronous active-low reset
//   remote_ptr_gray  in   write pointer, Gray coded, asynchronous to clk
//   local_inc        in   advance the read pointer by one
//   local_ptr_bin    out  read pointer, binary (registered)
//   local_ptr_gray   out  read pointer, Gray (registered alongside binary)
//   remote_ptr_bin   out  synchronised and decoded write pointer (registered)
//   occupancy        out  remote_ptr_bin - local_ptr_bin, modulo 2**PTR_WIDTH
//   empty            out  occupancy == 0
//   full             out  occupancy == 2**(PTR_WIDTH-1)
//   level_low        out  occupancy < LOW_MARK
//   level_high       out  occupancy > HIGH_MARK
//   gray_err         out  sticky sync-integrity error
//
// Build option: define GRAY_PTR_CHECK_EN to build the integrity checker.
// Without it, gray_err is tied to 0 and no check logic exists.

module gray_ptr_sync_tracker #(
   parameter int PTR_WIDTH   = 5,
   parameter int SYNC_STAGES = 2,
   parameter int LOW_MARK    = 6,
   parameter int HIGH_MARK   = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PTR_WIDTH-1:0] remote_ptr_gray,
   input  logic                 local_inc,
   output logic [PTR_WIDTH-1:0] local_ptr_bin,
   output logic [PTR_WIDTH-1:0] local_ptr_gray,
   output logic [PTR_WIDTH-1:0] remote_ptr_bin,
   output logic [PTR_WIDTH-1:0] occupancy,
   output logic                 empty,
   output logic                 full,
   output logic                 level_low,
   output logic                 level_high,
   output logic                 gray_err
);

   localparam logic [PTR_WIDTH-1:0] DEPTH  = PTR_WIDTH'(1) << (PTR_WIDTH - 1);
   localparam logic [PTR_WIDTH-1:0] LOW_W  = PTR_WIDTH'(LOW_MARK);
   localparam logic [PTR_WIDTH-1:0] HIGH_W = PTR_WIDTH'(HIGH_MARK);

   // ------------------------------------------------------------------
   // Code conversion helpers
   // ------------------------------------------------------------------
   // Each binary bit is the XOR of all Gray bits at or above its position.
   function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
      logic [PTR_WIDTH-1:0] b;
      b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
      for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PTR_WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [PTR_WIDTH-1:0] r_remote_bin;
   logic [PTR_WIDTH-1:0] r_local_bin;
   logic [PTR_WIDTH-1:0] r_local_gray;

   logic [PTR_WIDTH-1:0] w_sync_out;
   logic [PTR_WIDTH-1:0] w_occupancy;
   logic                 w_empty;
   logic                 w_local_adv;
   logic [PTR_WIDTH-1:0] w_local_nxt;

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Write-pointer synchroniser. Only Gray values enter the chain, so a
   // sample taken mid-transition resolves to either the old or the new
   // pointer, never to an unrelated value.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            r_sync[k] <= '0;
         end
      end else begin
         r_sync[0] <= remote_ptr_gray;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
      end
   end

   // Decode after the last synchroniser stage. This register adds the
   // final cycle of the SYNC_STAGES+1 latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_remote_bin <= '0;
      end else begin
         r_remote_bin <= gray2bin(w_sync_out);
      end
   end

   // ------------------------------------------------------------------
   // Occupancy and flags come from registers only, so nothing on an input
   // reaches an output in the same cycle. Modulo subtraction handles
   // pointer wrap. The extra wrap bit separates full from empty.
   // ------------------------------------------------------------------
   assign w_occupancy = r_remote_bin - r_local_bin;
   assign w_empty     = (w_occupancy == '0);

   // ------------------------------------------------------------------
   // Local read pointer. Binary and Gray copies load on the same edge, so
   // the Gray copy is always the exact encoding of the binary copy.
   // ------------------------------------------------------------------
   assign w_local_adv = local_inc & ~w_empty;
   assign w_local_nxt = r_local_bin + {{(PTR_WIDTH-1){1'b0}}, w_local_adv};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_local_bin  <= '0;
         r_local_gray <= '0;
      end else begin
         r_local_bin  <= w_local_nxt;
         r_local_gray <= bin2gray(w_local_nxt);
      end
   end

   // ------------------------------------------------------------------
   // Optional integrity checker
   // ------------------------------------------------------------------
`ifdef GRAY_PTR_CHECK_EN
   logic [PTR_WIDTH-1:0] r_prev_gray;
   logic                 r_gray_err;
   logic [PTR_WIDTH-1:0] w_gray_diff;
   logic                 w_multi_bit;
   logic                 w_overrun;

   // A legal Gray step flips at most one bit. "d & (d-1)" clears the lowest
   // set bit, so a non-zero result means two or more bits changed.
   assign w_gray_diff = w_sync_out ^ r_prev_gray;
   assign w_multi_bit = |(w_gray_diff & (w_gray_diff - PTR_WIDTH'(1)));
   // More than a full buffer can only mean the writer lapped the reader.
   assign w_overrun   = (w_occupancy > DEPTH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev_gray <= '0;
         r_gray_err  <= 1'b0;
      end else begin
         r_prev_gray <= w_sync_out;
         r_gray_err  <= r_gray_err | w_multi_bit | w_overrun;
      end
   end

   assign gray_err = r_gray_err;
`else
   assign gray_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign local_ptr_bin  = r_local_bin;
   assign local_ptr_gray = r_local_gray;
   assign remote_ptr_bin = r_remote_bin;
   assign occupancy      = w_occupancy;
   assign empty          = w_empty;
   assign full           = (w_occupancy == DEPTH);
   assign level_low      = (w_occupancy < LOW_W);
   assign level_high     = (w_occupancy > HIGH_W);

endmodule

// File: tb/tb_gray_ptr_sync_tracker.sv
// Purpose     : scoreboard bench for gray_ptr_sync_tracker (PTR_WIDTH=5, SYNC_STAGES=2, marks 6/10).
// Latency     : expected snapshots are queued with a target cycle; remote_ptr_bin changes are checked for value and cycle.
// Backpressure: not applicable; stimulus is free-running against the clock.

module tb_gray_ptr_sync_tracker;

`ifdef GRAY_PTR_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] remote_ptr_gray;
   logic       local_inc;
   logic [4:0] local_ptr_bin;
   logic [4:0] local_ptr_gray;
   logic [4:0] remote_ptr_bin;
   logic [4:0] occupancy;
   logic       empty;
   logic       full;
   logic       level_low;
   logic       level_high;
   logic       gray_err;

   gray_ptr_sync_tracker #(
      .PTR_WIDTH   (5),
      .SYNC_STAGES (2),
      .LOW_MARK    (6),
      .HIGH_MARK   (10)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .remote_ptr_gray (remote_ptr_gray),
      .local_inc       (local_inc),
      .local_ptr_bin   (local_ptr_bin),
      .local_ptr_gray  (local_ptr_gray),
      .remote_ptr_bin  (remote_ptr_bin),
      .occupancy       (occupancy),
      .empty           (empty),
      .full            (full),
      .level_low       (level_low),
      .level_high      (level_high),
      .gray_err        (gray_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // Snapshot layout: {lb, lg, rb, occ, empty, full, low, high, err}
   typedef struct {
      int          at;
      string       name;
      logic [24:0] vec;
   } snap_t;

   typedef struct {
      logic [4:0] val;
      int         at;
   } rchg_t;

   snap_t q_snap [$];
   rchg_t q_rem  [$];
   logic [4:0] last_drv = 5'd0;
   logic [4:0] r_seen   = 5'd0;
   bit         mon_en   = 1'b0;

   function automatic logic [24:0] mk(input logic [4:0] lb, input logic [4:0] lg,
                                      input logic [4:0] rb, input logic [4:0] occ,
                                      input logic [4:0] fl);
      return {lb, lg, rb, occ, fl};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int dly, input string nm, input logic [24:0] v);
      snap_t s;
      s.at = cyc + dly;
      s.name = nm;
      s.vec = v;
      q_snap.push_back(s);
   endtask

   // Drives the write pointer as Gray and queues the resulting
   // remote_ptr_bin change, due three cycles after the drive.
   task automatic drive_remote(input logic [4:0] b);
      rchg_t r;
      remote_ptr_gray = b ^ (b >> 1);
      if (b != last_drv) begin
         r.val = b;
         r.at  = cyc + 3;
         q_rem.push_back(r);
      end
      last_drv = b;
   endtask

   // Asserts reset for one edge. A non-zero remote_ptr_bin drops to 0 on
   // that edge, so queue that change when one is expected.
   task automatic reset_pulse(input logic rb_nonzero);
      rchg_t r;
      rst_n = 1'b0;
      remote_ptr_gray = 5'd0;
      if (rb_nonzero) begin
         r.val = 5'd0;
         r.at  = cyc + 1;
         q_rem.push_back(r);
      end
      last_drv = 5'd0;
      tick();
   endtask

   // Monitor: compares timed snapshots and every remote_ptr_bin change.
   always @(negedge clk) begin
      logic [24:0] act;
      act = {local_ptr_bin, local_ptr_gray, remote_ptr_bin, occupancy,
             empty, full, level_low, level_high, gray_err};
      for (int i = q_snap.size() - 1; i >= 0; i--) begin
         if (q_snap[i].at <= cyc) begin
            tests++;
            if (q_snap[i].at < cyc) begin
               fails++;
               $display("FAIL %s: snapshot due cycle %0d not sampled (now %0d)",
                        q_snap[i].name, q_snap[i].at, cyc);
            end else if (act !== q_snap[i].vec) begin
               fails++;
               $display("FAIL %s @%0d: got lb=%0d lg=%b rb=%0d occ=%0d e/f/l/h/err=%b, want lb=%0d lg=%b rb=%0d occ=%0d e/f/l/h/err=%b",
                        q_snap[i].name, cyc,
                        act[24:20], act[19:15], act[14:10], act[9:5], act[4:0],
                        q_snap[i].vec[24:20], q_snap[i].vec[19:15], q_snap[i].vec[14:10],
                        q_snap[i].vec[9:5], q_snap[i].vec[4:0]);
            end
            q_snap.delete(i);
         end
      end
      if (!mon_en) begin
         r_seen = remote_ptr_bin;
      end else if (remote_ptr_bin !== r_seen) begin
         tests++;
         if (q_rem.size() == 0) begin
            fails++;
            $display("FAIL remote_chg: unexpected remote_ptr_bin=%0d at cycle %0d", remote_ptr_bin, cyc);
         end else begin
            rchg_t e;
            e = q_rem.pop_front();
            if (remote_ptr_bin !== e.val || cyc != e.at) begin
               fails++;
               $display("FAIL remote_chg: got %0d at cycle %0d, want %0d at cycle %0d",
                        remote_ptr_bin, cyc, e.val, e.at);
            end
         end
         r_seen = remote_ptr_bin;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // Hand-computed tables
   logic [4:0] c3_lb  [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5, 5'd5};
   logic [4:0] c3_lg  [7] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00111, 5'b00111};
   logic [4:0] c3_occ [7] = '{5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0};
   logic [4:0] c3_fl  [7] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b10100, 5'b10100, 5'b10100};
   logic [4:0] c4_lb  [5] = '{5'd29, 5'd30, 5'd31, 5'd0, 5'd1};
   logic [4:0] c4_lg  [5] = '{5'b10011, 5'b10001, 5'b10000, 5'b00000, 5'b00001};
   logic [4:0] c4_occ [5] = '{5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
   logic [4:0] c4_rem [6] = '{5'd29, 5'd30, 5'd31, 5'd0, 5'd1, 5'd2};

   initial begin
      // Case 1: reset with garbage on the remote input
      rst_n = 1'b0;
      local_inc = 1'b0;
      remote_ptr_gray = 5'b10110;
      repeat (3) tick();
      expect_at(0, "c1_reset", mk(0, 0, 0, 0, 5'b10100));
      mon_en = 1'b1;
      rst_n = 1'b1;
      drive_remote(5'd0);
      tick();

      // Case 2: remote walks 0..5 in Gray, one step per cycle
      for (int i = 0; i < 6; i++) begin
         drive_remote(5'(i));
         expect_at(3, "c2_remote", mk(0, 0, 5'(i), 5'(i), (i == 0) ? 5'b10100 : 5'b00100));
         tick();
      end
      repeat (3) tick();
      expect_at(0, "c2_final", mk(0, 0, 5, 5, 5'b00100));

      // Case 3: hold local_inc for 7 cycles; pointer must stop at 5
      local_inc = 1'b1;
      for (int j = 0; j < 7; j++) begin
         expect_at(j + 1, "c3_inc", mk(c3_lb[j], c3_lg[j], 5, c3_occ[j], c3_fl[j]));
      end
      repeat (7) tick();
      local_inc = 1'b0;
      tick();

      // Case 4: bring both pointers to 28, then wrap across 31->0
      local_inc = 1'b1;
      for (int b = 6; b <= 28; b++) begin
         drive_remote(5'(b));
         tick();
      end
      repeat (6) tick();
      local_inc = 1'b0;
      tick();
      expect_at(0, "c4_catchup", mk(28, 5'b10010, 28, 0, 5'b10100));
      for (int i = 0; i < 6; i++) begin
         drive_remote(c4_rem[i]);
         tick();
      end
      repeat (3) tick();
      expect_at(0, "c4_occ6", mk(28, 5'b10010, 2, 6, 5'b00000));
      local_inc = 1'b1;
      for (int j = 0; j < 5; j++) begin
         expect_at(j + 1, "c4_wrap", mk(c4_lb[j], c4_lg[j], 2, c4_occ[j], 5'b00100));
      end
      repeat (5) tick();
      local_inc = 1'b0;
      tick();

      // Case 5: mid-run reset, then fill to depth; simultaneous update
      reset_pulse(1'b1);
      expect_at(0, "c5_reset", mk(0, 0, 0, 0, 5'b10100));
      rst_n = 1'b1;
      tick();
      for (int b = 1; b <= 16; b++) begin
         drive_remote(5'(b));
         tick();
      end
      repeat (3) tick();
      expect_at(0, "c5_full", mk(0, 0, 16, 16, 5'b01010));
      drive_remote(5'd17);
      expect_at(2, "c5_pre", mk(0, 0, 16, 16, 5'b01010));
      expect_at(3, "c5_simul", mk(1, 5'b00001, 17, 16, 5'b01010));
      tick();
      tick();
      local_inc = 1'b1;
      tick();
      local_inc = 1'b0;
      tick();

      // Case 6: two-bit Gray jump 00000->00011
      reset_pulse(1'b1);
      reset_pulse(1'b0);
      rst_n = 1'b1;
      tick();
      tick();
      drive_remote(5'd2);
      expect_at(2, "c6_pre", mk(0, 0, 0, 0, 5'b10100));
      expect_at(3, "c6_err", mk(0, 0, 2, 2, {4'b0010, ERR_EN}));
      expect_at(6, "c6_sticky", mk(0, 0, 2, 2, {4'b0010, ERR_EN}));
      repeat (6) tick();
      reset_pulse(1'b1);
      expect_at(0, "c6_reset", mk(0, 0, 0, 0, 5'b10100));
      rst_n = 1'b1;
      repeat (4) tick();
      expect_at(0, "c6_after", mk(0, 0, 0, 0, 5'b10100));
      repeat (3) tick();

      // Anything still queued was never observed.
      while (q_snap.size() > 0) begin
         snap_t s;
         s = q_snap.pop_front();
         tests++;
         fails++;
         $display("FAIL %s: snapshot due cycle %0d never checked", s.name, s.at);
      end
      while (q_rem.size() > 0) begin
         rchg_t r;
         r = q_rem.pop_front();
         tests++;
         fails++;
         $display("FAIL remote_chg: expected change to %0d at cycle %0d never seen", r.val, r.at);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
